// File: rtl/eha_fcs_pkg.sv
// Shared constants and state encoding for the Ethernet FCS checker.
package eha_fcs_pkg;

  // Reflected CRC-32 (IEEE 802.3) parameters
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  // Register value left after running a frame plus its correct FCS through the CRC
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Legal frame length window in bytes, FCS included
  localparam int unsigned DEF_MIN_FRAME = 64;
  localparam int unsigned DEF_MAX_FRAME = 1522;

  // IDLE: window empty, FILL: 1-3 bytes held, STREAM: 4 bytes held
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } fcs_state_t;

endpackage

// File: rtl/crc32_byte_next.sv
// One-byte step of the reflected (LSB-first) CRC-32. Purely combinational.
module crc32_byte_next
  import eha_fcs_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  // Fold the byte into the low bits, then shift out eight bits through the polynomial
  always_comb begin
    crc_work = crc_in ^ {24'h00_0000, byte_in};
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_work[0]) begin
        crc_work = (crc_work >> 1) ^ CRC_POLY;
      end else begin
        crc_work = crc_work >> 1;
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/eth_fcs_checker.sv
// Ingress FCS checker: validates the Ethernet CRC-32, strips the 4 FCS bytes,
// flags bad/runt/oversize/PHY-errored frames on tuser with tlast, and keeps
// good/bad/drop frame statistics.
module eth_fcs_checker
  import eha_fcs_pkg::*;
#(
  parameter int unsigned MIN_FRAME = DEF_MIN_FRAME,
  parameter int unsigned MAX_FRAME = DEF_MAX_FRAME,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             FCS_clk,
  input  logic             FCS_rst,
  input  logic [7:0]       FCSi_tdata,
  input  logic             FCSi_tvalid,
  output logic             FCSi_tready,
  input  logic             FCSi_tlast,
  input  logic             FCSi_tuser,
  output logic [7:0]       FCSo_tdata,
  output logic             FCSo_tvalid,
  input  logic             FCSo_tready,
  output logic             FCSo_tlast,
  output logic             FCSo_tuser,
  output logic [CNT_W-1:0] FCS_good_cnt,
  output logic [CNT_W-1:0] FCS_bad_cnt,
  output logic [CNT_W-1:0] FCS_drop_cnt
);

  localparam logic [11:0]      MIN_LEN = 12'(MIN_FRAME);
  localparam logic [11:0]      MAX_LEN = 12'(MAX_FRAME);
  localparam logic [11:0]      CNT_SAT = 12'hFFF;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fcs_state_t      state;
  logic [1:0]      fill_cnt;
  logic [3:0][7:0] win;        // win[3] is the oldest byte held
  logic [31:0]     crc;
  logic [31:0]     crc_next;
  logic [11:0]     byte_cnt;
  logic [11:0]     cnt_next;
  logic            phy_err;

  logic            advance;
  logic            accept;
  logic            acc_last;
  logic            emit;
  logic            frame_err;

  crc32_byte_next u_crc (
    .crc_in  (crc),
    .byte_in (FCSi_tdata),
    .crc_out (crc_next)
  );

  // Handshake and per-byte decisions; frame_err folds in the tlast byte itself
  always_comb begin
    advance   = !(FCSo_tvalid && !FCSo_tready);
    accept    = FCSi_tvalid && advance;
    acc_last  = accept && FCSi_tlast;
    emit      = accept && (state == ST_STREAM);
    cnt_next  = (byte_cnt == CNT_SAT) ? byte_cnt : byte_cnt + 12'd1;
    frame_err = (crc_next != CRC_RESIDUE) || (cnt_next < MIN_LEN) ||
                (cnt_next > MAX_LEN) || phy_err || FCSi_tuser;
  end

  assign FCSi_tready = advance;

  // Frame tracking: window shift, fill state, running CRC, length and sticky PHY error
  always_ff @(posedge FCS_clk or negedge FCS_rst) begin
    if (!FCS_rst) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
      win      <= '0;
      crc      <= CRC_INIT;
      byte_cnt <= '0;
      phy_err  <= 1'b0;
    end else if (accept) begin
      win <= {win[2:0], FCSi_tdata};
      if (FCSi_tlast) begin
        state    <= ST_IDLE;
        fill_cnt <= '0;
        crc      <= CRC_INIT;
        byte_cnt <= '0;
        phy_err  <= 1'b0;
      end else begin
        crc      <= crc_next;
        byte_cnt <= cnt_next;
        phy_err  <= phy_err || FCSi_tuser;
        case (state)
          ST_IDLE: begin
            state    <= ST_FILL;
            fill_cnt <= 2'd1;
          end
          ST_FILL: begin
            if (fill_cnt == 2'd3) begin
              state <= ST_STREAM;
            end else begin
              fill_cnt <= fill_cnt + 2'd1;
            end
          end
          ST_STREAM: state <= ST_STREAM;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output register: loads only when the downstream slot is free
  always_ff @(posedge FCS_clk or negedge FCS_rst) begin
    if (!FCS_rst) begin
      FCSo_tvalid <= 1'b0;
      FCSo_tdata  <= '0;
      FCSo_tlast  <= 1'b0;
      FCSo_tuser  <= 1'b0;
    end else if (advance) begin
      FCSo_tvalid <= emit;
      FCSo_tlast  <= emit && FCSi_tlast;
      FCSo_tuser  <= emit && FCSi_tlast && frame_err;
      if (emit) begin
        FCSo_tdata <= win[3];
      end
    end
  end

  // Frame statistics: good/bad on an emitted tlast, drop on a swallowed short frame
  always_ff @(posedge FCS_clk or negedge FCS_rst) begin
    if (!FCS_rst) begin
      FCS_good_cnt <= '0;
      FCS_bad_cnt  <= '0;
      FCS_drop_cnt <= '0;
    end else begin
      if (emit && FCSi_tlast) begin
        if (frame_err) begin
          FCS_bad_cnt <= FCS_bad_cnt + CNT_ONE;
        end else begin
          FCS_good_cnt <= FCS_good_cnt + CNT_ONE;
        end
      end
      if (acc_last && (state != ST_STREAM)) begin
        FCS_drop_cnt <= FCS_drop_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/eth_fcs_checker.md
Name: eth_fcs_checker

Overview:
- Ingress stage directly upstream of the L2/L3 frame buffer. It takes the raw byte stream from the MAC receive side and checks the Ethernet CRC-32 FCS.
- It strips the 4 FCS bytes from the frame.
- It flags bad, runt, oversize or PHY-errored frames by asserting tuser with tlast. The buffer uses that flag to drop the frame (restart line).
- It keeps per-frame good, bad and drop counters.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, including FCS.
- MAX_FRAME, 1522, maximum legal frame length in bytes, including FCS.
- CNT_W, 16, width of the statistics counters.

Ports:
- FCS_clk  in  1  clock.
- FCS_rst  in  1  asynchronous, active-low reset.
- FCSi_tdata  in  8  input byte.
- FCSi_tvalid  in  1  input valid.
- FCSi_tready  out  1  input ready.
- FCSi_tlast  in  1  last byte of frame; this is the final FCS byte.
- FCSi_tuser  in  1  PHY/MAC error on this byte.
- FCSo_tdata  out  8  payload byte.
- FCSo_tvalid  out  1  output valid.
- FCSo_tready  in  1  output ready.
- FCSo_tlast  out  1  last payload byte.
- FCSo_tuser  out  1  frame bad; meaningful only with FCSo_tlast.
- FCS_good_cnt  out  CNT_W  frames passed clean; wraps.
- FCS_bad_cnt  out  CNT_W  frames emitted with tuser=1; wraps.
- FCS_drop_cnt  out  CNT_W  frames of 4 bytes or fewer, swallowed; wraps.

Behaviour:
- Reset values (FCS_rst=0, asynchronous): all outputs 0, all counters 0, CRC register = 0xFFFFFFFF, byte count 0, window empty, state IDLE.
- Advance and accept:
  - advance = !(FCSo_tvalid & !FCSo_tready).
  - FCSi_tready = advance.
  - accept = FCSi_tvalid & advance.
- Output register: one registered stage. FCSo_* change only when advance=1. When advance=1 and there is no emit, FCSo_tvalid goes to 0 on the next edge.
- Window: a 4-byte shift register holding the most recent accepted bytes. The fill count is tracked by the state machine.
- State machine:
  - IDLE → FILL on accept without tlast.
  - FILL: holds 1–3 bytes. Moves to STREAM once the 4th byte is accepted.
  - STREAM: holds 4 bytes.
  - Any state → IDLE on accept with tlast.
- STREAM, accept without tlast: emit the oldest window byte (tlast=0, tuser=0) and shift in the new byte.
- STREAM, accept with tlast: emit the oldest window byte with tlast=1 and tuser=err. This byte is the last payload byte; the 3 newer window bytes plus the input byte are the FCS and are discarded.
- IDLE/FILL, accept with tlast (frame of 4 bytes or fewer): nothing is emitted. Increment FCS_drop_cnt and return to IDLE.
- CRC-32:
  - Reflected, LSB-first, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Updated on every accepted byte, FCS bytes included.
  - Re-initialised after each accepted tlast.
  - The good-frame check uses the next-CRC value of the tlast byte: it must equal 0xDEBB20E3.
- Byte count: 12-bit, saturating at 4095. It includes the tlast byte.
- err is the OR of:
  - CRC mismatch;
  - count < MIN_FRAME;
  - count > MAX_FRAME;
  - sticky FCSi_tuser seen on any accepted byte of the frame, including the tlast byte.
- Counters: on an emitted tlast, increment FCS_good_cnt if err=0, otherwise FCS_bad_cnt. They update in the same edge as the FCSo_tlast register.
- Latency:
  - The first output byte is valid on the edge that accepts input byte 5.
  - Steady state is one byte per cycle with no bubbles while FCSo_tready=1.
- Back-to-back frames: a new frame's first byte may be accepted in the cycle right after the tlast accept, with no idle cycle needed.
- Backpressure: while FCSo_tvalid=1 and FCSo_tready=0, FCSi_tready=0 and all state is frozen. No byte is lost or duplicated.
- Reset mid-frame: the partial frame is discarded and no tlast is emitted. The downstream buffer's own reset is responsible for the partial line.

Decomposition:
- Package eha_fcs_pkg holds:
  - constants CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3;
  - the default MIN_FRAME and MAX_FRAME values;
  - the state encoding IDLE/FILL/STREAM.
- Sub-module crc32_byte_next: purely combinational, inputs (crc_in[31:0], byte[7:0]), output crc_out[31:0]. It is unit-testable against a software model.

Test Plan:
- Good frame: 64-byte frame (60 bytes 0x00..0x3B plus correct FCS), FCSo_tready=1. Expect 60 output bytes 0x00..0x3B, tlast on 0x3B, tuser=0, good_cnt=1, first output one edge after input byte 5.
- Corrupt byte: same frame with byte 10 flipped to 0xFF. Expect 60 bytes out, tlast with tuser=1, bad_cnt=1, good_cnt unchanged.
- Runt: 40-byte frame with valid FCS. Expect 36 bytes out, tuser=1 at tlast. 3-byte frame: no output, drop_cnt=1, next good frame passes clean.
- Oversize and PHY error:
  - 1523-byte valid-FCS frame → tuser=1.
  - 64-byte frame with FCSi_tuser=1 on byte 20 → tuser=1.
- Backpressure: FCSo_tready low for 5 cycles mid-frame and randomly 50% elsewhere. Expect FCSi_tready to track advance, output stream identical to the unstalled case, counters unchanged in meaning.
- Reset mid-frame: FCS_rst low for 1 cycle after 30 bytes. Expect all outputs and counters 0 immediately (asynchronous). A following good 64-byte frame then gives 60 bytes and good_cnt=1.
